uat_fsm: RTL and testbench

UAT_FSM -- requirements
Module: uat_fsm

---
 rtl/uat_fsm.sv | 165 ++++++++++++++++
 tb/tb_uat_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uat_fsm.sv
// rtl/uat_fsm.sv - serial packet transmitter: GAP, START, DATA, STOP framing.
// Optional even-parity bit between DATA and STOP when UAT_PARITY_EN is defined.
module uat_fsm #(
   parameter int          CLK_HZ       = 65_000_000,
   parameter int          BAUD_RATE    = 9600,
   parameter int          CLKS_PER_BIT = CLK_HZ / BAUD_RATE,
   parameter int          PKT_LNGTH    = 162,
   parameter logic [31:0] IDLE_CYCLES  = 32'd1_300_000
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic [PKT_LNGTH-1:0] data_in,
   input  logic                 valid_in,
   output logic                 busy_out,
   output logic                 done_out,
   output logic                 tx_out
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GAP    = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UAT_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;
`endif

   localparam logic [31:0] LP_CPB_M1   = 32'(CLKS_PER_BIT - 1);
   localparam logic [31:0] LP_GAP_M1   = IDLE_CYCLES - 32'd1;
   localparam logic [7:0]  LP_LAST_BIT = 8'(PKT_LNGTH - 1);

   logic [1:0]           r_rst_sync;
   logic                 w_rst_n;
   logic [2:0]           r_state;
   logic [2:0]           w_next;
   logic [31:0]          r_cnt;
   logic [31:0]          w_cnt_next;
   logic [7:0]           r_bit;
   logic [7:0]           w_bit_next;
   logic [PKT_LNGTH-1:0] r_shift;
   logic [PKT_LNGTH-1:0] w_shift_next;
   logic                 r_tx;
   logic                 w_tx_next;
`ifdef UAT_PARITY_EN
   logic                 r_parity;
   logic                 w_parity_next;
`endif

   // Assertion is immediate; release reaches the FSM two edges later.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_rst_sync <= 2'b00;
      else           r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
`ifdef UAT_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt_next;
         r_bit    <= w_bit_next;
         r_shift  <= w_shift_next;
         r_tx     <= w_tx_next;
`ifdef UAT_PARITY_EN
         r_parity <= w_parity_next;
`endif
      end
   end

   always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt + 32'd1;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
`ifdef UAT_PARITY_EN
      w_parity_next = r_parity;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            if (valid_in) begin
               w_next       = S_GAP;
               w_shift_next = data_in;
`ifdef UAT_PARITY_EN
               w_parity_next = ^data_in;
`endif
            end
         end
         S_GAP: begin
            if (r_cnt == LP_GAP_M1) begin
               w_next     = S_START;
               w_cnt_next = '0;
            end
         end
         S_START: begin
            if (r_cnt == LP_CPB_M1) begin
               w_next     = S_DATA;
               w_cnt_next = '0;
            end
         end
         S_DATA: begin
            if (r_cnt == LP_CPB_M1) begin
               w_cnt_next = '0;
               if (r_bit == LP_LAST_BIT) begin
                  w_bit_next = '0;
`ifdef UAT_PARITY_EN
                  w_next     = S_PARITY;
`else
                  w_next     = S_STOP;
`endif
               end else begin
                  w_bit_next   = r_bit + 8'd1;
                  w_shift_next = r_shift >> 1;
               end
            end
         end
`ifdef UAT_PARITY_EN
         S_PARITY: begin
            if (r_cnt == LP_CPB_M1) begin
               w_next     = S_STOP;
               w_cnt_next = '0;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == LP_CPB_M1) begin
               w_next     = S_IDLE;
               w_cnt_next = '0;
            end
         end
         default: begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
            w_bit_next = '0;
         end
      endcase

      // Line level is registered from the upcoming state so it changes with the state.
      w_tx_next = 1'b1;
      case (w_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UAT_PARITY_EN
         S_PARITY: w_tx_next = r_parity;
`endif
         default:  w_tx_next = 1'b1;
      endcase
   end

   always_comb begin
      busy_out = (r_state != S_IDLE);
      done_out = (r_state == S_STOP) && (r_cnt == LP_CPB_M1);
      tx_out   = r_tx;
   end

endmodule

// File: tb/tb_uat_fsm.sv
// tb/tb_uat_fsm.sv - randomized bench for uat_fsm against a per-cycle line-level queue model.
// Define UAT_PARITY_EN for both files to exercise the parity build.
module tb_uat_fsm;

   localparam int CPB    = 4;
   localparam int IDLE_C = 8;
   localparam int PKT    = 8;
`ifdef UAT_PARITY_EN
   localparam int PAR    = 1;
`else
   localparam int PAR    = 0;
`endif
   localparam int PLEN   = IDLE_C + (PKT + 2 + PAR) * CPB;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           valid = 1'b0;
   logic [PKT-1:0] data = '0;
   logic           busy;
   logic           done;
   logic           tx;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;
   bit q[$];

   uat_fsm #(
      .CLKS_PER_BIT (CPB),
      .PKT_LNGTH    (PKT),
      .IDLE_CYCLES  (32'(IDLE_C))
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .data_in  (data),
      .valid_in (valid),
      .busy_out (busy),
      .done_out (done),
      .tx_out   (tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected line level for every cycle of a packet, in transmit order.
   function automatic void push_pkt(input logic [PKT-1:0] d);
      repeat (IDLE_C) q.push_back(1'b1);
      repeat (CPB) q.push_back(1'b0);
      for (int i = 0; i < PKT; i++) repeat (CPB) q.push_back(d[i]);
      if (PAR != 0) repeat (CPB) q.push_back(^d);
      repeat (CPB) q.push_back(1'b1);
   endfunction

   always @(negedge rst_n) q.delete();

   always @(posedge clk) begin
      if (!rst_n)             q.delete();
      else if (q.size() == 0) begin
         if (valid) push_pkt(data);
      end else                void'(q.pop_front());
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic etx;
         etx = (q.size() != 0) ? q[0] : 1'b1;
         chk("outputs{tx,busy,done}", {61'd0, tx, busy, done},
             {61'd0, etx, q.size() != 0, q.size() == 1});
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   task automatic send_cap(input logic [PKT-1:0] d, output logic [63:0] wave,
                           output int dcnt, output int dcyc);
      @(posedge clk); #1;
      valid = 1'b1;
      data  = d;
      @(posedge clk); #1;
      valid = 1'b0;
      wave = '0;
      dcnt = 0;
      dcyc = 0;
      for (int k = 1; k <= PLEN + 2; k++) begin
         @(negedge clk);
         if (k <= PLEN) wave = {wave[62:0], tx};
         if (done) begin
            dcnt++;
            dcyc = k;
         end
      end
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      logic [63:0] wave;
      int          dcnt;
      int          dcyc;
      logic        b49;
      logic        b50;

      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx",   {63'd0, tx},   64'd1);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      rst_n = 1'b1;

      dcnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("idle_done_count", 64'(dcnt), 64'd0);
      chk("idle_tx",         {63'd0, tx},   64'd1);
      chk("idle_busy",       {63'd0, busy}, 64'd0);

`ifndef UAT_PARITY_EN
      // A5 with an ignored FF request mid-packet and a request straddling the stop edge.
      @(posedge clk); #1;
      valid = 1'b1;
      data  = 8'hA5;
      @(posedge clk); #1;
      valid = 1'b0;
      wave = '0;
      dcnt = 0;
      dcyc = 0;
      b49  = 1'b1;
      b50  = 1'b0;
      for (int k = 1; k <= 52; k++) begin
         @(negedge clk);
         if (k <= 48) wave = {wave[62:0], tx};
         if (done) begin
            dcnt++;
            dcyc = k;
         end
         if (k == 20) begin valid = 1'b1; data = 8'hFF; end
         if (k == 24) valid = 1'b0;
         if (k == 48) begin valid = 1'b1; data = 8'h3C; end
         if (k == 49) b49 = busy;
         if (k == 50) begin b50 = busy; valid = 1'b0; end
      end
      chk("a5_wave",        wave, 64'hFF0F0F00F0FF);
      chk("a5_done_count",  64'(dcnt), 64'd1);
      chk("a5_done_cycle",  64'(dcyc), 64'd48);
      chk("stop_edge_busy", {63'd0, b49}, 64'd0);
      chk("next_accept",    {63'd0, b50}, 64'd1);
      wait_idle();
`endif

      // Reset pulse in the middle of data bit 3 (bit 3 of F7 is 0).
      @(posedge clk); #1;
      valid = 1'b1;
      data  = 8'hF7;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (26) @(negedge clk);
      chk("pre_reset_tx", {63'd0, tx}, 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_tx",   {63'd0, tx},   64'd1);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

`ifndef UAT_PARITY_EN
      send_cap(8'h3C, wave, dcnt, dcyc);
      chk("3c_wave",       wave, 64'hFF000FFFF00F);
      chk("3c_done_count", 64'(dcnt), 64'd1);
      chk("3c_done_cycle", 64'(dcyc), 64'd48);
`else
      send_cap(8'h07, wave, dcnt, dcyc);
      chk("par07_wave",       wave, 64'hFF0FFF00000FF);
      chk("par07_done_count", 64'(dcnt), 64'd1);
      chk("par07_length",     64'(dcyc), 64'd52);
      send_cap(8'h03, wave, dcnt, dcyc);
      chk("par03_wave",       wave, 64'hFF0FF0000000F);
      chk("par03_length",     64'(dcyc), 64'd52);
`endif

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         if (i >= 700 && i < 704) begin
            rst_n = (i != 700);
            valid = 1'b0;
         end else begin
            valid = ($urandom_range(0, 7) == 0);
            data  = PKT'($urandom);
         end
      end
      @(posedge clk); #1;
      valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
